hmac_sha1_ctrl: RTL
===================

Name: hmac_sha1_ctrl

Overview:
Sequencer that computes HMAC-SHA1 over a 64-bit message (a TOTP/HOTP counter) with a 512-bit zero-padded key. It drives an external sha1_core through its four-block schedule: inner key, inner message, outer key, outer digest. It exposes a single req/done handshake so the TOTP top, or any other requester, treats HMAC as one operation. A watchdog flags a core that never returns ready.

Parameters:
TIMEOUT, 1023, max cycles spent waiting for core_ready per block before abort with err
IPAD_BYTE, 8'h36, inner pad byte, replicated to 512 bits
OPAD_BYTE, 8'h5c, outer pad byte, replicated to 512 bits

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
req  input  1  start pulse; sampled only in IDLE
req_key  input  512  key, left-aligned, zero-padded; latched on accepted req
req_msg  input  64  message/counter; latched on accepted req
busy  output  1  high from the cycle after accept until done/err
done  output  1  one-cycle pulse, mac valid
mac  output  160  HMAC result; held until next done
err  output  1  one-cycle pulse on watchdog timeout
core_init  output  1  one-cycle pulse, first block of a hash
core_next  output  1  one-cycle pulse, continuation block
core_block  output  512  block presented to the core; stable while waiting
core_ready  input  1  core idle/finished
core_digest  input  160  core digest, sampled when core_ready is seen

Behaviour:
- Reset values: busy=0, done=0, err=0, mac=0, core_init=0, core_next=0, core_block=0, state IDLE, watchdog=0. Reset mid-operation aborts immediately. No done and no err follow the reset.
- States: IDLE -> IK -> WIK -> IM -> WIM -> OK -> WOK -> OM -> WOM -> DONE -> IDLE.
- IDLE: if req is high, latch key and msg and go to IK. A req while busy is ignored, not queued.
- IK: core_block = key ^ {64{IPAD_BYTE}}, core_init=1 for this cycle only.
- IM: core_block = {msg, 1'b1, 383'b0, 64'd576}, core_next=1.
- OK: core_block = key ^ {64{OPAD_BYTE}}, core_init=1.
- OM: core_block = {inner_digest, 1'b1, 287'b0, 64'd672}, core_next=1.
- W* states:
  - The first cycle ignores core_ready (arming cycle), because the core's ready may still be stale-high.
  - From the second cycle on, core_ready=1 advances the state.
  - In WIM, core_digest is latched to inner_digest on the advance. In WOM, it is latched to mac.
- DONE: done=1 for one cycle; busy drops in the same cycle. Back-to-back: a req in the cycle after DONE is accepted.
- Latency with a zero-wait core: 4 pulse + 8 wait + 1 done cycles, so 13 cycles from accept to done.
- Watchdog:
  - Counts cycles in each W* state; clears on every state change.
  - Reaching TIMEOUT gives err=1 for one cycle, a return to IDLE, busy=0, and mac unchanged.
- Pulses: core_init/core_next are never both high. Each is never high for two consecutive cycles.
- The key is never modified in place; pads are applied combinationally from the latched key.
- Length fields are fixed: 576 = 512+64 bits, 672 = 512+160 bits.

Decomposition:
- Shared package hmac_pkg holds:
  - state encoding localparams;
  - BLK_W=512, DIG_W=160, MSG_W=64;
  - LEN_INNER=64'd576, LEN_OUTER=64'd672;
  - pad byte constants.
- One natural sub-module, hmac_block_mux: a combinational selector producing core_block from state, key, msg and inner_digest. It is a small, separately testable module. The FSM and watchdog stay in hmac_sha1_ctrl.

Test Plan:
- RFC 4226 key 0x3132333435363738393031323334353637383930 zero-padded, msg=0 -> done with mac=cc93cf18508d94934c64b65d8ba7667fb7cde4b0.
- Same key, msg=1 issued the cycle after the previous done -> accepted; mac=75a48a19d4cbe100644e8ac1397eea747a2d33ab.
- req pulsed repeatedly while busy -> exactly one done. Block sequence observed on core_block is exactly IK, IM, OK, OM. One init/next pulse each.
- Core model holds core_ready=1 during the arming cycle then 0 for 80 cycles -> controller does not advance early; result still matches RFC vector.
- Core model never raises core_ready after IK with TIMEOUT=1023 -> err pulses at cycle 1023 of WIK, busy=0, mac keeps previous value, next req succeeds.
- rst asserted in WOK -> next cycle all outputs at reset values; no done/err; a subsequent req yields a correct mac.

Source files
------------

// File: rtl/hmac_pkg.sv
// Shared constants and state encoding for the HMAC-SHA1 sequencer.
// The state encoding is shared so the block selector can follow the controller's FSM.
package hmac_pkg;

  localparam int BLK_W = 512;
  localparam int DIG_W = 160;
  localparam int MSG_W = 64;

  // Bit lengths of the padded messages: key block plus payload.
  localparam logic [63:0] LEN_INNER = 64'd576;
  localparam logic [63:0] LEN_OUTER = 64'd672;

  localparam logic [7:0] IPAD_DEF = 8'h36;
  localparam logic [7:0] OPAD_DEF = 8'h5c;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_IK   = 4'd1,
    S_WIK  = 4'd2,
    S_IM   = 4'd3,
    S_WIM  = 4'd4,
    S_OK   = 4'd5,
    S_WOK  = 4'd6,
    S_OM   = 4'd7,
    S_WOM  = 4'd8,
    S_DONE = 4'd9
  } state_t;

  function automatic logic is_wait(input state_t s);
    return (s == S_WIK) || (s == S_WIM) || (s == S_WOK) || (s == S_WOM);
  endfunction

endpackage

// File: rtl/hmac_block_mux.sv
// Selects the 512-bit block shown to the SHA-1 core from the sequencer state.
// Wait states keep presenting the block of the preceding pulse, so the block stays stable.
module hmac_block_mux
  import hmac_pkg::*;
#(
  parameter logic [7:0] IPAD_BYTE = IPAD_DEF,
  parameter logic [7:0] OPAD_BYTE = OPAD_DEF
) (
  input  state_t             state,
  input  logic [BLK_W-1:0]   key,
  input  logic [MSG_W-1:0]   msg,
  input  logic [DIG_W-1:0]   inner_digest,
  output logic [BLK_W-1:0]   block
);

  always_comb begin
    block = '0;
    case (state)
      S_IK, S_WIK: block = key ^ {64{IPAD_BYTE}};
      S_IM, S_WIM: block = {msg, 1'b1, 383'b0, LEN_INNER};
      S_OK, S_WOK: block = key ^ {64{OPAD_BYTE}};
      S_OM, S_WOM: block = {inner_digest, 1'b1, 287'b0, LEN_OUTER};
      default:     block = '0;
    endcase
  end

endmodule

// File: rtl/hmac_sha1_ctrl.sv
// HMAC-SHA1 sequencer: runs an external SHA-1 core through inner key, inner message,
// outer key and outer digest blocks behind one req/done handshake, with a per-block watchdog.
module hmac_sha1_ctrl
  import hmac_pkg::*;
#(
  parameter int         TIMEOUT   = 1023,
  parameter logic [7:0] IPAD_BYTE = IPAD_DEF,
  parameter logic [7:0] OPAD_BYTE = OPAD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [BLK_W-1:0] req_key,
  input  logic [MSG_W-1:0] req_msg,
  output logic             busy,
  output logic             done,
  output logic [DIG_W-1:0] mac,
  output logic             err,
  output logic             core_init,
  output logic             core_next,
  output logic [BLK_W-1:0] core_block,
  input  logic             core_ready,
  input  logic [DIG_W-1:0] core_digest
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [WD_W-1:0]  wd;
  logic [BLK_W-1:0] key_q;
  logic [MSG_W-1:0] msg_q;
  logic [DIG_W-1:0] inner_q;
  logic             adv;
  logic             expired;

  // wd == 0 marks the arming cycle, where a stale core_ready must be ignored.
  assign adv     = is_wait(state) && (wd != '0) && core_ready;
  assign expired = (wd == WD_W'(TIMEOUT - 1));

  hmac_block_mux #(
    .IPAD_BYTE (IPAD_BYTE),
    .OPAD_BYTE (OPAD_BYTE)
  ) u_mux (
    .state        (state),
    .key          (key_q),
    .msg          (msg_q),
    .inner_digest (inner_q),
    .block        (core_block)
  );

  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      key_q <= req_key;
      msg_q <= req_msg;
    end
    if (state == S_WIM && adv) begin
      inner_q <= core_digest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mac       <= '0;
      core_init <= 1'b0;
      core_next <= 1'b0;
      wd        <= '0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      core_init <= 1'b0;
      core_next <= 1'b0;
      case (state)
        S_IDLE: begin
          wd <= '0;
          if (req) begin
            state     <= S_IK;
            busy      <= 1'b1;
            core_init <= 1'b1;
          end
        end
        S_IK: state <= S_WIK;
        S_IM: state <= S_WIM;
        S_OK: state <= S_WOK;
        S_OM: state <= S_WOM;
        S_WIK, S_WIM, S_WOK, S_WOM: begin
          if (adv) begin
            wd <= '0;
            case (state)
              S_WIK: begin state <= S_IM; core_next <= 1'b1; end
              S_WIM: begin state <= S_OK; core_init <= 1'b1; end
              S_WOK: begin state <= S_OM; core_next <= 1'b1; end
              default: begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
                mac   <= core_digest;
              end
            endcase
          end else if (expired) begin
            // Core never answered: abandon the operation, keep the previous mac.
            wd    <= '0;
            state <= S_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
